pe_lsu_load_align: RTL and testbench

Load-return side of the PE data-memory interface. The PE AGU issues a read; this block records the access descriptor (opcode, low address bits, signedness, destination register) in a small in-order FIFO. When DMEM returns the 32-bit read word, the block pops the descriptor, extracts the addressed word/half-word/byte lane, sign- or zero-extends it, and presents a registered write-back to the PE register file. It sits between the AGU/DMEM request path and the PE write-back stage.

---
 rtl/pe_lsu_load_align_pkg.sv | 33 +++
 rtl/pe_lsu_load_extract.sv | 51 +++++
 rtl/pe_lsu_load_align.sv | 140 ++++++++++++++
 tb/tb_pe_lsu_load_align.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_lsu_load_align_pkg.sv
// rtl/pe_lsu_load_align_pkg.sv - PE data width, LSU opcode encodings and load-queue defaults
//
// Purpose: shared constants for the PE load-return path.
//   DEF_PE_DATA_WIDTH        : width of a DMEM word / PE register
//   RISC24_PE_LSU_OP_WIDTH   : width of the LSU opcode field
//   RISC24_LSU_OP_*          : opcode encodings (any other code passes data unchanged)
//   DEF_PE_LSU_PENDING_DEPTH : default number of outstanding loads
//   lsu_is_misaligned()      : misalignment rule used when PE_LSU_MISALIGN_CHECK_EN is defined
package pe_lsu_load_align_pkg;

    localparam int DEF_PE_DATA_WIDTH        = 32;
    localparam int RISC24_PE_LSU_OP_WIDTH   = 2;
    localparam int DEF_PE_LSU_PENDING_DEPTH = 2;

    localparam logic [RISC24_PE_LSU_OP_WIDTH-1:0] RISC24_LSU_OP_BYTE      = 2'd0;
    localparam logic [RISC24_PE_LSU_OP_WIDTH-1:0] RISC24_LSU_OP_HALF_WORD = 2'd1;
    localparam logic [RISC24_PE_LSU_OP_WIDTH-1:0] RISC24_LSU_OP_WORD      = 2'd2;

    // Half-words must sit on an even address, words on a multiple of four.
    function automatic logic lsu_is_misaligned(
        input logic [RISC24_PE_LSU_OP_WIDTH-1:0] opcode,
        input logic [1:0]                        addr_low
    );
        logic mis;
        mis = 1'b0;
        if (opcode == RISC24_LSU_OP_HALF_WORD)
            mis = addr_low[0];
        else if (opcode == RISC24_LSU_OP_WORD)
            mis = (addr_low != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/pe_lsu_load_extract.sv
// rtl/pe_lsu_load_extract.sv - combinational lane select and sign/zero extension of a load word
//
// Purpose: picks the addressed word/half-word/byte out of a raw DMEM word and
// extends it to the full data width. Shared with the CP load path.
// Ports:
//   opcode       : LSU opcode (word / half-word / byte / other)
//   addr_low     : address bits [1:0] of the access
//   load_signed  : 1 = sign-extend, 0 = zero-extend (ignored for word)
//   raw_data     : raw DMEM read word
//   aligned_data : extracted, extended result
module pe_lsu_load_extract
    import pe_lsu_load_align_pkg::*;
(
    input  logic [RISC24_PE_LSU_OP_WIDTH-1:0] opcode,
    input  logic [1:0]                        addr_low,
    input  logic                              load_signed,
    input  logic [DEF_PE_DATA_WIDTH-1:0]      raw_data,
    output logic [DEF_PE_DATA_WIDTH-1:0]      aligned_data
);

    logic [15:0] half_lane;
    logic [7:0]  byte_lane;
    logic        half_fill;
    logic        byte_fill;

    always_comb begin
        half_lane = addr_low[1] ? raw_data[31:16] : raw_data[15:0];
        case (addr_low)
            2'd0:    byte_lane = raw_data[7:0];
            2'd1:    byte_lane = raw_data[15:8];
            2'd2:    byte_lane = raw_data[23:16];
            default: byte_lane = raw_data[31:24];
        endcase
        half_fill = load_signed & half_lane[15];
        byte_fill = load_signed & byte_lane[7];
    end

    always_comb begin
        case (opcode)
            RISC24_LSU_OP_WORD:
                aligned_data = raw_data;
            RISC24_LSU_OP_HALF_WORD:
                aligned_data = {{(DEF_PE_DATA_WIDTH-16){half_fill}}, half_lane};
            RISC24_LSU_OP_BYTE:
                aligned_data = {{(DEF_PE_DATA_WIDTH-8){byte_fill}}, byte_lane};
            default:
                aligned_data = raw_data;
        endcase
    end

endmodule

// File: rtl/pe_lsu_load_align.sv
// rtl/pe_lsu_load_align.sv - in-order load descriptor FIFO and aligned register write-back
//
// Purpose: records each load's descriptor at issue, pops it when DMEM returns
// the read word, and presents a registered, aligned and extended write-back.
// Optional feature: define PE_LSU_MISALIGN_CHECK_EN to generate oLSU_Misalign;
// otherwise it is tied low.
// Ports:
//   iClk, iReset                   : clock, asynchronous active-high reset
//   iAGU_LSU_*                     : load request and its descriptor fields
//   oLSU_Stall                     : descriptor FIFO full, upstream holds its request
//   iDMEM_LSU_Read_Valid/_Data     : in-order DMEM read return
//   oLSU_WB_Valid/_Data/_Reg       : one-cycle write-back pulse, data and register
//   oLSU_Protocol_Error            : sticky, response arrived with no load pending
//   oLSU_Misalign                  : misaligned-access pulse alongside write-back
module pe_lsu_load_align
    import pe_lsu_load_align_pkg::*;
#(
    parameter int DEPTH          = DEF_PE_LSU_PENDING_DEPTH,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                              iClk,
    input  logic                              iReset,
    input  logic                              iAGU_LSU_Read_Enable,
    input  logic [RISC24_PE_LSU_OP_WIDTH-1:0] iAGU_LSU_Opcode,
    input  logic [1:0]                        iAGU_LSU_Addr_Low,
    input  logic                              iAGU_LSU_Load_Signed,
    input  logic [REG_ADDR_WIDTH-1:0]         iAGU_LSU_Dest_Reg,
    output logic                              oLSU_Stall,
    input  logic                              iDMEM_LSU_Read_Valid,
    input  logic [DEF_PE_DATA_WIDTH-1:0]      iDMEM_LSU_Read_Data,
    output logic                              oLSU_WB_Valid,
    output logic [DEF_PE_DATA_WIDTH-1:0]      oLSU_WB_Data,
    output logic [REG_ADDR_WIDTH-1:0]         oLSU_WB_Reg,
    output logic                              oLSU_Protocol_Error,
    output logic                              oLSU_Misalign
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic [RISC24_PE_LSU_OP_WIDTH-1:0] op_mem   [DEPTH];
    logic [1:0]                        addr_mem [DEPTH];
    logic                              sign_mem [DEPTH];
    logic [REG_ADDR_WIDTH-1:0]         dest_mem [DEPTH];

    logic push;
    logic pop;
    logic orphan_response;

    logic [RISC24_PE_LSU_OP_WIDTH-1:0] head_op;
    logic [1:0]                        head_addr;
    logic                              head_sign;
    logic [REG_ADDR_WIDTH-1:0]         head_dest;
    logic [DEF_PE_DATA_WIDTH-1:0]      head_data;

    // Stall looks only at the registered count, so a same-cycle pop does not
    // free a slot for a same-cycle push.
    assign oLSU_Stall      = (count == FULL_COUNT);
    assign push            = iAGU_LSU_Read_Enable && !oLSU_Stall;
    assign pop             = iDMEM_LSU_Read_Valid && (count != '0);
    assign orphan_response = iDMEM_LSU_Read_Valid && (count == '0);

    // Descriptor storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge iClk) begin
        if (push) begin
            op_mem[wr_ptr]   <= iAGU_LSU_Opcode;
            addr_mem[wr_ptr] <= iAGU_LSU_Addr_Low;
            sign_mem[wr_ptr] <= iAGU_LSU_Load_Signed;
            dest_mem[wr_ptr] <= iAGU_LSU_Dest_Reg;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

    assign head_op   = op_mem[rd_ptr];
    assign head_addr = addr_mem[rd_ptr];
    assign head_sign = sign_mem[rd_ptr];
    assign head_dest = dest_mem[rd_ptr];

    pe_lsu_load_extract u_extract (
        .opcode       (head_op),
        .addr_low     (head_addr),
        .load_signed  (head_sign),
        .raw_data     (iDMEM_LSU_Read_Data),
        .aligned_data (head_data)
    );

    // Data and register hold their last values between pops.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            oLSU_WB_Valid       <= 1'b0;
            oLSU_WB_Data        <= '0;
            oLSU_WB_Reg         <= '0;
            oLSU_Protocol_Error <= 1'b0;
        end else begin
            oLSU_WB_Valid <= pop;
            if (pop) begin
                oLSU_WB_Data <= head_data;
                oLSU_WB_Reg  <= head_dest;
            end
            if (orphan_response)
                oLSU_Protocol_Error <= 1'b1;
        end
    end

`ifdef PE_LSU_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset)
            misalign_q <= 1'b0;
        else
            misalign_q <= pop && lsu_is_misaligned(head_op, head_addr);
    end

    assign oLSU_Misalign = misalign_q;
`else
    assign oLSU_Misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pe_lsu_load_align.sv
// tb/tb_pe_lsu_load_align.sv - self-checking bench for pe_lsu_load_align
module tb_pe_lsu_load_align;
    import pe_lsu_load_align_pkg::*;

    localparam int DEPTH = 2;
`ifdef PE_LSU_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iAGU_LSU_Read_Enable;
    logic [1:0]  iAGU_LSU_Opcode;
    logic [1:0]  iAGU_LSU_Addr_Low;
    logic        iAGU_LSU_Load_Signed;
    logic [4:0]  iAGU_LSU_Dest_Reg;
    logic        oLSU_Stall;
    logic        iDMEM_LSU_Read_Valid;
    logic [31:0] iDMEM_LSU_Read_Data;
    logic        oLSU_WB_Valid;
    logic [31:0] oLSU_WB_Data;
    logic [4:0]  oLSU_WB_Reg;
    logic        oLSU_Protocol_Error;
    logic        oLSU_Misalign;

    pe_lsu_load_align #(.DEPTH(DEPTH), .REG_ADDR_WIDTH(5)) dut (
        .iClk                 (iClk),
        .iReset               (iReset),
        .iAGU_LSU_Read_Enable (iAGU_LSU_Read_Enable),
        .iAGU_LSU_Opcode      (iAGU_LSU_Opcode),
        .iAGU_LSU_Addr_Low    (iAGU_LSU_Addr_Low),
        .iAGU_LSU_Load_Signed (iAGU_LSU_Load_Signed),
        .iAGU_LSU_Dest_Reg    (iAGU_LSU_Dest_Reg),
        .oLSU_Stall           (oLSU_Stall),
        .iDMEM_LSU_Read_Valid (iDMEM_LSU_Read_Valid),
        .iDMEM_LSU_Read_Data  (iDMEM_LSU_Read_Data),
        .oLSU_WB_Valid        (oLSU_WB_Valid),
        .oLSU_WB_Data         (oLSU_WB_Data),
        .oLSU_WB_Reg          (oLSU_WB_Reg),
        .oLSU_Protocol_Error  (oLSU_Protocol_Error),
        .oLSU_Misalign        (oLSU_Misalign)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [1:0] op;
        logic [1:0] addr;
        logic       sgn;
        logic [4:0] dest;
    } load_desc_t;

    load_desc_t  pending[$];
    logic [31:0] m_data;
    logic [4:0]  m_reg;
    logic        m_valid;
    logic        m_err;
    logic        m_mis;

    int tests_run = 0;
    int failures  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lane extraction from plain shift/modulo arithmetic.
    function automatic logic [31:0] ref_extract(input logic [1:0] op, input logic [1:0] a,
                                                input logic s, input logic [31:0] d);
        int unsigned v;
        if (op == RISC24_LSU_OP_BYTE) begin
            v = (d >> (8 * a)) % 256;
            if (s && v >= 128) v = v - 256;
        end else if (op == RISC24_LSU_OP_HALF_WORD) begin
            v = (d >> (16 * (a / 2))) % 65536;
            if (s && v >= 32768) v = v - 65536;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic logic ref_misaligned(input logic [1:0] op, input logic [1:0] a);
        return ((op == RISC24_LSU_OP_HALF_WORD) && (a % 2 == 1)) ||
               ((op == RISC24_LSU_OP_WORD) && (a != 0));
    endfunction

    task automatic drive_idle();
        iAGU_LSU_Read_Enable = 1'b0;
        iAGU_LSU_Opcode      = 2'd0;
        iAGU_LSU_Addr_Low    = 2'd0;
        iAGU_LSU_Load_Signed = 1'b0;
        iAGU_LSU_Dest_Reg    = 5'd0;
        iDMEM_LSU_Read_Valid = 1'b0;
        iDMEM_LSU_Read_Data  = 32'd0;
    endtask

    task automatic model_reset();
        pending.delete();
        m_data  = 32'd0;
        m_reg   = 5'd0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_mis   = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        iReset = 1'b1;
        model_reset();
        @(posedge iClk);
        #1;
        iReset = 1'b0;
    endtask

    // One clock: drive request/response, predict, clock, compare. Called at posedge+1.
    task automatic cycle(input logic en, input logic [1:0] op, input logic [1:0] a,
                         input logic s, input logic [4:0] d,
                         input logic rv, input logic [31:0] rdata);
        load_desc_t e;
        load_desc_t h;
        bit         was_full;
        iAGU_LSU_Read_Enable = en;
        iAGU_LSU_Opcode      = op;
        iAGU_LSU_Addr_Low    = a;
        iAGU_LSU_Load_Signed = s;
        iAGU_LSU_Dest_Reg    = d;
        iDMEM_LSU_Read_Valid = rv;
        iDMEM_LSU_Read_Data  = rdata;
        #1;
        was_full = (pending.size() == DEPTH);
        check("stall", {31'd0, oLSU_Stall}, {31'd0, was_full});
        m_valid = 1'b0;
        m_mis   = 1'b0;
        if (rv) begin
            if (pending.size() > 0) begin
                h       = pending.pop_front();
                m_valid = 1'b1;
                m_data  = ref_extract(h.op, h.addr, h.sgn, rdata);
                m_reg   = h.dest;
                m_mis   = MIS_EN && ref_misaligned(h.op, h.addr);
            end else begin
                m_err = 1'b1;
            end
        end
        if (en && !was_full) begin
            e.op = op; e.addr = a; e.sgn = s; e.dest = d;
            pending.push_back(e);
        end
        @(posedge iClk);
        #1;
        check("wb_valid", {31'd0, oLSU_WB_Valid}, {31'd0, m_valid});
        check("wb_data", oLSU_WB_Data, m_data);
        check("wb_reg", {27'd0, oLSU_WB_Reg}, {27'd0, m_reg});
        check("proto_err", {31'd0, oLSU_Protocol_Error}, {31'd0, m_err});
        check("misalign", {31'd0, oLSU_Misalign}, {31'd0, m_mis});
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] byte_signed_exp   [4];
        logic [31:0] byte_unsigned_exp [4];
        byte_signed_exp   = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
        byte_unsigned_exp = '{32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};

        drive_idle();
        iReset = 1'b1;
        model_reset();
        repeat (2) @(posedge iClk);
        #1;
        check("rst_wb_valid", {31'd0, oLSU_WB_Valid}, 32'd0);
        check("rst_wb_data", oLSU_WB_Data, 32'd0);
        check("rst_wb_reg", {27'd0, oLSU_WB_Reg}, 32'd0);
        check("rst_stall", {31'd0, oLSU_Stall}, 32'd0);
        check("rst_err", {31'd0, oLSU_Protocol_Error}, 32'd0);
        check("rst_mis", {31'd0, oLSU_Misalign}, 32'd0);
        iReset = 1'b0;

        // Word load
        cycle(1, RISC24_LSU_OP_WORD, 2'd0, 1'b0, 5'd3, 0, 32'd0);
        cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 1, 32'hDEADBEEF);
        check("word_data", oLSU_WB_Data, 32'hDEADBEEF);
        check("word_reg", {27'd0, oLSU_WB_Reg}, 32'd3);

        // Byte lanes, unsigned then signed
        for (int sg = 0; sg < 2; sg++) begin
            for (int k = 0; k < 4; k++) begin
                cycle(1, RISC24_LSU_OP_BYTE, 2'(k), 1'(sg), 5'(k + 4), 0, 32'd0);
                cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 1, 32'h80FF7F01);
                check(sg ? "byte_signed" : "byte_unsigned", oLSU_WB_Data,
                      sg ? byte_signed_exp[k] : byte_unsigned_exp[k]);
            end
        end

        // Half-word at address 2
        cycle(1, RISC24_LSU_OP_HALF_WORD, 2'd2, 1'b1, 5'd8, 0, 32'd0);
        cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 1, 32'h80011234);
        check("half_signed", oLSU_WB_Data, 32'hFFFF8001);
        cycle(1, RISC24_LSU_OP_HALF_WORD, 2'd2, 1'b0, 5'd8, 0, 32'd0);
        cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 1, 32'h80011234);
        check("half_unsigned", oLSU_WB_Data, 32'h00008001);

        // Misalignment flag (expected high only with the feature built in)
        cycle(1, RISC24_LSU_OP_HALF_WORD, 2'd1, 1'b0, 5'd9, 0, 32'd0);
        cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 1, 32'h12345678);
        check("mis_half_a1", {31'd0, oLSU_Misalign}, {31'd0, MIS_EN});
        cycle(1, RISC24_LSU_OP_BYTE, 2'd3, 1'b0, 5'd9, 0, 32'd0);
        cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 1, 32'h12345678);
        check("mis_byte_a3", {31'd0, oLSU_Misalign}, 32'd0);
        cycle(1, RISC24_LSU_OP_WORD, 2'd2, 1'b0, 5'd9, 0, 32'd0);
        cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 1, 32'h12345678);

        // Full, held push not recorded, in-order pops
        cycle(1, RISC24_LSU_OP_WORD, 2'd0, 1'b0, 5'd1, 0, 32'd0);
        cycle(1, RISC24_LSU_OP_WORD, 2'd0, 1'b0, 5'd2, 0, 32'd0);
        check("stall_full", {31'd0, oLSU_Stall}, 32'd1);
        cycle(1, RISC24_LSU_OP_WORD, 2'd0, 1'b0, 5'd7, 0, 32'd0);
        cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 1, 32'h11111111);
        check("stall_released", {31'd0, oLSU_Stall}, 32'd0);
        check("pop_order_1", {27'd0, oLSU_WB_Reg}, 32'd1);
        cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 1, 32'h22222222);
        check("pop_order_2", {27'd0, oLSU_WB_Reg}, 32'd2);

        // Simultaneous push/pop at count 1, then at full (push blocked)
        cycle(1, RISC24_LSU_OP_WORD, 2'd0, 1'b0, 5'd9, 0, 32'd0);
        cycle(1, RISC24_LSU_OP_WORD, 2'd0, 1'b0, 5'd10, 1, 32'h33333333);
        cycle(1, RISC24_LSU_OP_WORD, 2'd0, 1'b0, 5'd11, 0, 32'd0);
        cycle(1, RISC24_LSU_OP_WORD, 2'd0, 1'b0, 5'd12, 1, 32'h44444444);
        check("full_pushpop_stall", {31'd0, oLSU_Stall}, 32'd0);
        cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 1, 32'h55555555);
        check("full_pushpop_reg", {27'd0, oLSU_WB_Reg}, 32'd11);

        // Orphan response: no write-back, sticky error
        cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 1, 32'h66666666);
        check("orphan_err", {31'd0, oLSU_Protocol_Error}, 32'd1);
        check("orphan_no_wb", {31'd0, oLSU_WB_Valid}, 32'd0);
        cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 0, 32'd0);

        // Reset mid-flight with two pending
        cycle(1, RISC24_LSU_OP_BYTE, 2'd1, 1'b1, 5'd13, 0, 32'd0);
        cycle(1, RISC24_LSU_OP_BYTE, 2'd2, 1'b1, 5'd14, 1, 32'h77777777);
        cycle(1, RISC24_LSU_OP_BYTE, 2'd2, 1'b1, 5'd15, 0, 32'd0);
        iReset = 1'b1;
        model_reset();
        #1;
        check("midrst_wb_valid", {31'd0, oLSU_WB_Valid}, 32'd0);
        check("midrst_wb_data", oLSU_WB_Data, 32'd0);
        check("midrst_wb_reg", {27'd0, oLSU_WB_Reg}, 32'd0);
        check("midrst_stall", {31'd0, oLSU_Stall}, 32'd0);
        check("midrst_err", {31'd0, oLSU_Protocol_Error}, 32'd0);
        @(posedge iClk);
        #1;
        iReset = 1'b0;
        cycle(0, 2'd0, 2'd0, 1'b0, 5'd0, 1, 32'h88888888);
        check("post_rst_err", {31'd0, oLSU_Protocol_Error}, 32'd1);

        // Randomized traffic against the queue model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic rv;
            rv = (pending.size() > 0) && ($urandom_range(0, 2) != 0);
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rv, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
